rdm_data_sink: RTL
==================

RDM_DATA_SINK -- requirements
Module: rdm_data_sink

Interface
REQ-001 Parameter DATA_WIDTH, default 96, SHALL set the width of one RDM word (16 soft bits of 6 bits each).
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the width of the write-buffer address.
REQ-003 Parameter PREP_CYCLES, default 4, SHALL set the wait between the combine request pulse and request assertion.
REQ-004 Parameter TIMEOUT, default 1023, SHALL set the maximum idle cycles allowed in RECEIVE.
REQ-005 Port i_core_clk, input, 1: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port i_rx_rstn, input, 1: reset, asynchronous and active-low.
REQ-007 Port i_start, input, 1: one-cycle pulse that starts a transfer for one user.
REQ-008 Port i_user_index, input, 4: user to combine, sampled on accepted i_start.
REQ-009 Port i_Ncb_Size, input, 16: expected soft-bit count, sampled on accepted i_start.
REQ-010 Port o_Combine_process_request, output, 1: one-cycle pulse to the RDM producer.
REQ-011 Port o_Combine_user_index, output, 4: registered user index, stable from the request pulse to DONE.
REQ-012 Port o_RDM_Data_Request, output, 1: level request to the producer.
REQ-013 Ports i_RDM_Data_Valid (1), i_RDM_Data_Comp (1) and i_RDM_Data_Content (DATA_WIDTH): inputs, word strobe, last-word flag and word data.
REQ-014 Ports o_Wr_En (1), o_Wr_Addr (ADDR_WIDTH) and o_Wr_Data (DATA_WIDTH): outputs, the combine-buffer write port.
REQ-015 Ports o_busy, o_done, o_err_len, o_err_ovf and o_err_timeout: outputs, 1 bit each; o_word_count: output, 16 bits.

Function
REQ-016 The state machine SHALL have one-hot states IDLE, REQ, SETTLE, RECEIVE and DONE.
REQ-017 IDLE: an i_start pulse SHALL go to REQ, latch the user index and Ncb, clear the word count and all error flags, and set expected words = ceil(Ncb/16) = Ncb[15:4] + (Ncb[3:0] != 0).
REQ-018 REQ: o_Combine_process_request SHALL be 1 for exactly this cycle; next state is SETTLE.
REQ-019 SETTLE: the FSM SHALL stay for exactly PREP_CYCLES cycles, then go to RECEIVE.
REQ-020 RECEIVE: o_RDM_Data_Request SHALL be 1 in every RECEIVE cycle and 0 in every other state.
REQ-021 RECEIVE: each cycle with i_RDM_Data_Valid=1 SHALL write the word with one cycle of latency: o_Wr_En=1, o_Wr_Addr = word count before increment, o_Wr_Data = the captured content; the word count then increments.
REQ-022 i_RDM_Data_Comp=1 SHALL move RECEIVE to DONE; if Valid=1 in the same cycle, that word SHALL still be written.
REQ-023 Comp without Valid SHALL write nothing extra.
REQ-024 DONE: o_done SHALL be 1 for exactly one cycle; o_err_len SHALL be set if word count != expected words; next state is IDLE.
REQ-025 Valid received when word count = 2^ADDR_WIDTH: no write, o_err_ovf set, count still increments; the count saturates at 0xFFFF.
REQ-026 Timeout counter: cleared on each Valid; reaching TIMEOUT SHALL set o_err_timeout and go to DONE, skipping the length check.
REQ-027 Valid or Comp outside RECEIVE SHALL be ignored.
REQ-028 i_start while o_busy=1 SHALL be ignored.
REQ-029 o_busy SHALL be 1 in REQ, SETTLE and RECEIVE.
REQ-030 Error flags SHALL be sticky until the next accepted i_start; o_word_count SHALL hold its final value after DONE.

Reset
REQ-031 On i_rx_rstn=0, the FSM SHALL go to IDLE immediately, asynchronously.
REQ-032 During reset, every output SHALL be 0, including data, address and counters.
REQ-033 Reset in the middle of a transfer SHALL drop o_RDM_Data_Request within the same cycle.
REQ-034 Reset in the middle of a transfer SHALL issue no o_done and no further writes.
REQ-035 After release, the first i_start SHALL behave as from power-up.

Verification
REQ-036 Nominal: i_start with Ncb=64, producer sends 4 Valid words (data 0..3) with Comp on the 4th -> request pulse at cycle 1, request high from cycle 6, writes addr 0..3 with data 0..3, o_done once, word count 4, no errors.
REQ-037 Partial word: Ncb=70, 5 words then Comp on a separate Valid=0 cycle -> 5 writes, o_err_len=0.
REQ-038 Length mismatch: Ncb=64, only 3 words then Comp -> o_err_len=1, o_done=1, word count 3.
REQ-039 Timeout: TIMEOUT=8, no Valid after request -> o_err_timeout=1 after 8 RECEIVE cycles, o_done=1, request low next cycle.
REQ-040 Reset mid-run: i_rx_rstn low after 2 words -> request low immediately, no o_done, all outputs 0; a new i_start completes normally.
REQ-041 Ignored inputs: i_start during RECEIVE, and Valid during SETTLE -> no effect on state, count or write port.

Source files
------------

// File: rtl/rdm_data_sink.sv
// Receives one user's RDM words from the producer and writes them into the combine buffer.
// It also reports the word count together with length, overflow and timeout errors.
module rdm_data_sink #(
  parameter int DATA_WIDTH  = 96,
  parameter int ADDR_WIDTH  = 12,
  parameter int PREP_CYCLES = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_start,
  input  logic [3:0]            i_user_index,
  input  logic [15:0]           i_Ncb_Size,
  output logic                  o_Combine_process_request,
  output logic [3:0]            o_Combine_user_index,
  output logic                  o_RDM_Data_Request,
  input  logic                  i_RDM_Data_Valid,
  input  logic                  i_RDM_Data_Comp,
  input  logic [DATA_WIDTH-1:0] i_RDM_Data_Content,
  output logic                  o_Wr_En,
  output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
  output logic [DATA_WIDTH-1:0] o_Wr_Data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_len,
  output logic                  o_err_ovf,
  output logic                  o_err_timeout,
  output logic [15:0]           o_word_count
);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    REQ     = 5'b00010,
    SETTLE  = 5'b00100,
    RECEIVE = 5'b01000,
    DONE    = 5'b10000
  } state_t;

  localparam logic [15:0] PREP_LAST = 16'(PREP_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [16:0] DEPTH     = 17'(2 ** ADDR_WIDTH);

  state_t                  state_reg, state_next;
  logic [3:0]              user_reg;
  logic [12:0]             expected_reg;
  logic [15:0]             count_reg;
  logic [15:0]             prep_cnt_reg;
  logic [15:0]             idle_cnt_reg;
  logic                    wr_en_reg;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg;
  logic [DATA_WIDTH-1:0]   wr_data_reg;
  logic                    err_len_reg;
  logic                    err_ovf_reg;
  logic                    err_to_reg;
  logic                    buffer_full;
  logic                    idle_expired;
  logic                    len_mismatch;

  assign buffer_full  = {1'b0, count_reg} >= DEPTH;
  assign idle_expired = !i_RDM_Data_Valid && (idle_cnt_reg == TO_LAST);
  // The length check is skipped when the transfer ended by timeout.
  assign len_mismatch = (state_reg == DONE) && !err_to_reg &&
                        (count_reg != {3'b000, expected_reg});

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = REQ;
      REQ:     state_next = SETTLE;
      SETTLE:  if (prep_cnt_reg == PREP_LAST) state_next = RECEIVE;
      RECEIVE: if (i_RDM_Data_Comp || idle_expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      user_reg     <= '0;
      expected_reg <= '0;
      count_reg    <= '0;
      prep_cnt_reg <= '0;
      idle_cnt_reg <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      err_len_reg  <= 1'b0;
      err_ovf_reg  <= 1'b0;
      err_to_reg   <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            user_reg     <= i_user_index;
            expected_reg <= {1'b0, i_Ncb_Size[15:4]} + {12'd0, |i_Ncb_Size[3:0]};
            count_reg    <= '0;
            err_len_reg  <= 1'b0;
            err_ovf_reg  <= 1'b0;
            err_to_reg   <= 1'b0;
          end
        end
        REQ: begin
          prep_cnt_reg <= '0;
        end
        SETTLE: begin
          prep_cnt_reg <= prep_cnt_reg + 16'd1;
          idle_cnt_reg <= '0;
        end
        RECEIVE: begin
          if (i_RDM_Data_Valid) begin
            idle_cnt_reg <= '0;
            if (buffer_full) begin
              err_ovf_reg <= 1'b1;
            end else begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= count_reg[ADDR_WIDTH-1:0];
              wr_data_reg <= i_RDM_Data_Content;
            end
            if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
          end else if (!i_RDM_Data_Comp) begin
            if (idle_expired) err_to_reg <= 1'b1;
            else              idle_cnt_reg <= idle_cnt_reg + 16'd1;
          end
        end
        DONE: begin
          if (len_mismatch) err_len_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_Combine_process_request = (state_reg == REQ);
  assign o_Combine_user_index      = user_reg;
  assign o_RDM_Data_Request        = (state_reg == RECEIVE);
  assign o_Wr_En                   = wr_en_reg;
  assign o_Wr_Addr                 = wr_addr_reg;
  assign o_Wr_Data                 = wr_data_reg;
  assign o_busy                    = (state_reg == REQ) || (state_reg == SETTLE) ||
                                     (state_reg == RECEIVE);
  assign o_done                    = (state_reg == DONE);
  assign o_err_len                 = err_len_reg | len_mismatch;
  assign o_err_ovf                 = err_ovf_reg;
  assign o_err_timeout             = err_to_reg;
  assign o_word_count              = count_reg;

endmodule
